// File: rtl/aes_iter_cipher.sv
// aes_iter_cipher: iterative AES-128/192/256 encryptor; one round per cycle, or two cycles per round
// when AES_ITER_SPLIT_EN is defined (adds mid_reg after ShiftRows). Round keys are fetched by rk_idx.
module aes_iter_cipher #(
  parameter int KEY_BITS = 128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);
  localparam int NR = KEY_BITS == 128 ? 10 : KEY_BITS == 192 ? 12 : 14;
  localparam logic [3:0] NR4 = 4'(NR);
  localparam logic [3:0] LAST = 4'(NR - 1);
  localparam logic [2:0] IDLE = 3'd0, INIT = 3'd1, ROUND = 3'd2, FINAL = 3'd3, DONE = 3'd4;
  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key
    $error("aes_iter_cipher: KEY_BITS must be 128, 192 or 256");
  end
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction
  logic [2:0]   fsm;
  logic [3:0]   rnd;
  logic [127:0] state_reg, sb, sr, pre, mc;
  logic         step;
  // Byte i sits at row i%4, column i/4; ShiftRows rotates row r left by r columns.
  for (genvar i = 0; i < 16; i++) begin : g_byte
    aes_sbox u_sbox (.a(state_reg[127-8*i -: 8]), .y(sb[127-8*i -: 8]));
    assign sr[127-8*i -: 8] = sb[127-8*((i % 4) + 4*(((i / 4) + (i % 4)) % 4)) -: 8];
  end
  for (genvar c = 0; c < 4; c++) begin : g_col
    assign mc[127-32*c -: 32] = mix_col(pre[127-32*c -: 32]);
  end
`ifdef AES_ITER_SPLIT_EN
  logic         ph;
  logic [127:0] mid_reg;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      ph <= 1'b0;
      mid_reg <= '0;
    end else if (flush) ph <= 1'b0;
    else if (fsm == ROUND || fsm == FINAL) begin
      ph <= ~ph;
      if (!ph) mid_reg <= sr;
    end
  assign step = ph;
  assign pre = mid_reg;
`else
  assign step = 1'b1;
  assign pre = sr;
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      fsm <= IDLE;
      rnd <= '0;
      state_reg <= '0;
    end else if (flush) begin
      fsm <= IDLE;
      rnd <= '0;
    end else case (fsm)
      IDLE: if (in_valid) begin
        state_reg <= in_data;
        rnd <= '0;
        fsm <= INIT;
      end
      INIT: begin
        state_reg <= state_reg ^ rk;
        rnd <= 4'd1;
        fsm <= ROUND;
      end
      ROUND: if (step) begin
        state_reg <= mc ^ rk;
        rnd <= rnd + 4'd1;
        if (rnd == LAST) fsm <= FINAL;
      end
      FINAL: if (step) begin
        state_reg <= pre ^ rk;
        fsm <= DONE;
      end
      DONE: if (out_ready) fsm <= IDLE;
      default: fsm <= IDLE;
    endcase
  assign rk_idx = fsm == ROUND ? rnd : fsm == FINAL ? NR4 : 4'd0;
  assign in_ready = fsm == IDLE;
  assign out_valid = fsm == DONE;
  assign out_data = state_reg;
  assign busy = fsm != IDLE;
endmodule

// Forward AES S-box as a packed lookup table, entry 0 in the top byte.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [2047:0] T = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  assign y = T[{~a, 3'b111} -: 8];
endmodule

// File: tb/tb_aes_iter_cipher.sv
// tb_aes_iter_cipher: drives AES-128/192/256 instances against FIPS-197 vectors and a byte-level
// reference cipher whose S-box is derived from GF(2^8) inversion plus the affine map.
module tb_aes_iter_cipher;
  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT [3] = '{128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                                     128'hdda97ca4864cdfe06eaf70a0ec0d7191,
                                     128'h8ea2b7ca516745bfeafc49904b496089};
  localparam logic [255:0] KEY [3] = '{
    256'h000102030405060708090a0b0c0d0e0f_00000000000000000000000000000000,
    256'h000102030405060708090a0b0c0d0e0f1011121314151617_0000000000000000,
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f};
`ifdef AES_ITER_SPLIT_EN
  localparam int SPLIT = 2;
`else
  localparam int SPLIT = 1;
`endif
  logic clk = 1'b0;
  logic rst, flush;
  logic in_valid [3], in_ready [3], out_valid [3], out_ready [3], busy [3];
  logic [127:0] in_data [3], rk [3], out_data [3];
  logic [3:0] rk_idx [3];
  logic [127:0] rks [3][16];
  logic [7:0] sbt [256];
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    aes_iter_cipher #(.KEY_BITS(128 + 64*g)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid[g]), .in_ready(in_ready[g]), .in_data(in_data[g]),
      .rk_idx(rk_idx[g]), .rk(rk[g]),
      .out_valid(out_valid[g]), .out_ready(out_ready[g]), .out_data(out_data[g]),
      .busy(busy[g]));
    assign rk[g] = rks[g][rk_idx[g]];
  end
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [8:0] t;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p ^= a;
      t = {a, 1'b0};
      a = t[8] ? t[7:0] ^ 8'h1b : t[7:0];
    end
    return p;
  endfunction
  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] d = {b, b};
    return d[15-n -: 8];
  endfunction
  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbt[w[31:24]], sbt[w[23:16]], sbt[w[15:8]], sbt[w[7:0]]};
  endfunction
  function automatic logic [127:0] ref_enc(input int g, input logic [127:0] pt);
    logic [7:0] s [16], t [16];
    logic [127:0] k, o;
    int nr = 10 + 2*g;
    k = rks[g][0];
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ k[127-8*i -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbt[s[(i % 4) + 4*(((i / 4) + (i % 4)) % 4)]];
      for (int c = 0; c < 4; c++)
        if (r < nr) begin
          s[4*c]   = gmul(t[4*c], 2) ^ gmul(t[4*c+1], 3) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 2) ^ gmul(t[4*c+2], 3) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 2) ^ gmul(t[4*c+3], 3);
          s[4*c+3] = gmul(t[4*c], 3) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 2);
        end else for (int j = 0; j < 4; j++) s[4*c+j] = t[4*c+j];
      k = rks[g][r];
      for (int i = 0; i < 16; i++) s[i] ^= k[127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h01;
      repeat (254) inv = gmul(inv, 8'(x));
      if (x == 0) inv = 8'h00;
      sbt[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask
  task automatic set_key(input int g, input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0] rc = 8'h01;
    int nk = 4 + 2*g;
    int nw = 4*(11 + 2*g);
    for (int i = 0; i < nw; i++)
      if (i < nk) w[i] = key[255-32*i -: 32];
      else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = gmul(rc, 8'h02);
        end else if (nk == 8 && i % nk == 4) t = subw(t);
        w[i] = w[i-nk] ^ t;
      end
    for (int r = 0; r < nw / 4; r++) rks[g][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask
  task automatic start(input int g, input logic [127:0] pt);
    @(negedge clk);
    in_data[g] = pt;
    in_valid[g] = 1'b1;
    @(posedge clk);
    #1 in_valid[g] = 1'b0;
  endtask
  task automatic encrypt(input int g, input logic [127:0] pt, input logic [127:0] exp,
                         input string nm, input int stall);
    logic [3:0] q [$];
    int cnt = 0;
    int nr = 10 + 2*g;
    bit ok;
    start(g, pt);
    while (!out_valid[g] && cnt < 100) begin
      if (q.size() == 0 || q[$] != rk_idx[g]) q.push_back(rk_idx[g]);
      @(posedge clk);
      #1 cnt++;
    end
    total++;
    if (cnt != SPLIT*nr + 1) $display("FAIL %s latency: got %0d edges, want %0d", nm, cnt, SPLIT*nr + 1);
    else passed++;
    total++;
    if (out_data[g] !== exp) $display("FAIL %s data: got %h, want %h", nm, out_data[g], exp);
    else passed++;
    ok = q.size() == nr + 1;
    foreach (q[i]) if (q[i] != 4'(i)) ok = 1'b0;
    total++;
    if (!ok) $display("FAIL %s rk_idx sequence: got %0d steps ending at %0d, want 0..%0d", nm, q.size(), q.size() ? q[$] : 0, nr);
    else passed++;
    for (int k = 0; k < stall; k++) begin
      @(posedge clk);
      #1 total++;
      if ({out_valid[g], in_ready[g], rk_idx[g], out_data[g]} !== {1'b1, 1'b0, 4'd0, exp})
        $display("FAIL %s stall cycle %0d: out_valid=%b in_ready=%b rk_idx=%0d data=%h, want 1 0 0 %h",
                 nm, k, out_valid[g], in_ready[g], rk_idx[g], out_data[g], exp);
      else passed++;
    end
    @(negedge clk);
    out_ready[g] = 1'b1;
    @(posedge clk);
    #1 out_ready[g] = 1'b0;
    total++;
    if ({in_ready[g], out_valid[g]} !== 2'b10)
      $display("FAIL %s after handshake: in_ready=%b out_valid=%b, want 1 0", nm, in_ready[g], out_valid[g]);
    else passed++;
  endtask
  task automatic check_idle(input int g, input string nm);
    total++;
    if ({in_ready[g], out_valid[g], busy[g], rk_idx[g], out_data[g]} !== {1'b1, 1'b0, 1'b0, 4'd0, 128'd0})
      $display("FAIL %s: in_ready=%b out_valid=%b busy=%b rk_idx=%0d out_data=%h, want 1 0 0 0 0",
               nm, in_ready[g], out_valid[g], busy[g], rk_idx[g], out_data[g]);
    else passed++;
  endtask
  task automatic test_reset();
    #2 rst = 1'b0;
    #1 for (int g = 0; g < 3; g++) check_idle(g, "reset");
    @(negedge clk);
    rst = 1'b1;
  endtask
  task automatic test_vectors();
    for (int g = 0; g < 3; g++) begin
      set_key(g, KEY[g]);
      encrypt(g, PT, CT[g], $sformatf("kat%0d", 128 + 64*g), 0);
    end
  endtask
  task automatic test_random();
    logic [255:0] key;
    logic [127:0] pt;
    for (int g = 0; g < 3; g++)
      repeat (3) begin
        key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        pt = {$urandom, $urandom, $urandom, $urandom};
        set_key(g, key);
        encrypt(g, pt, ref_enc(g, pt), $sformatf("rand%0d", 128 + 64*g), $urandom_range(0, 3));
      end
  endtask
  task automatic test_backpressure();
    set_key(0, KEY[0]);
    encrypt(0, PT, CT[0], "backpressure", 20);
  endtask
  task automatic test_flush();
    int cnt = 0;
    set_key(0, KEY[0]);
    start(0, {$urandom, $urandom, $urandom, $urandom});
    while (rk_idx[0] != 4'd5 && cnt < 50) begin
      @(posedge clk);
      #1 cnt++;
    end
    total++;
    if (cnt >= 50) $display("FAIL flush wait: rk_idx=%0d after %0d cycles, want 5", rk_idx[0], cnt);
    else passed++;
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    total++;
    if ({in_ready[0], out_valid[0], busy[0], rk_idx[0]} !== {1'b1, 1'b0, 1'b0, 4'd0})
      $display("FAIL flush: in_ready=%b out_valid=%b busy=%b rk_idx=%0d, want 1 0 0 0",
               in_ready[0], out_valid[0], busy[0], rk_idx[0]);
    else passed++;
    @(negedge clk);
    flush = 1'b1;
    in_valid[0] = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    in_valid[0] = 1'b0;
    total++;
    if ({in_ready[0], busy[0]} !== 2'b10)
      $display("FAIL flush with in_valid: in_ready=%b busy=%b, want 1 0", in_ready[0], busy[0]);
    else passed++;
    encrypt(0, PT, CT[0], "post_flush", 0);
  endtask
  task automatic test_async_reset();
    int cnt = 0;
    bit seen = 1'b0;
    start(0, PT);
    while (rk_idx[0] != 4'd10 && cnt < 50) begin
      @(posedge clk);
      #1 cnt++;
    end
    #2 rst = 1'b0;
    #1 check_idle(0, "async reset mid-final");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (30) begin
      @(posedge clk);
      #1 if (out_valid[0]) seen = 1'b1;
    end
    total++;
    if (seen || !in_ready[0]) $display("FAIL post-reset: out_valid seen=%b in_ready=%b, want 0 1", seen, in_ready[0]);
    else passed++;
  endtask
  task automatic test_back_to_back();
    logic [127:0] pt;
    set_key(1, KEY[1]);
    repeat (3) begin
      pt = {$urandom, $urandom, $urandom, $urandom};
      encrypt(1, pt, ref_enc(1, pt), "back_to_back", 0);
    end
  endtask
  initial begin
    rst = 1'b1;
    flush = 1'b0;
    for (int g = 0; g < 3; g++) begin
      in_valid[g] = 1'b0;
      out_ready[g] = 1'b0;
      in_data[g] = '0;
    end
    build_sbox();
    test_reset();
    test_vectors();
    test_random();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/aes_iter_cipher.md
# aes_iter_cipher

Iterative AES encryption core that applies one full cipher round per cycle, or per two cycles when split, to a 128-bit state held in a single register. It covers AES-128, AES-192 and AES-256 through a parameter. It fetches round keys by index from an external key-schedule store and uses valid/ready handshakes on input and output. It replaces chains of per-round instances in the cipher top level, trading throughput for area.

## Interface
Parameters:
- KEY_BITS, default 128: key size, legal values 128, 192 and 256. Nr = 10, 12 and 14 respectively. Any other value is an elaboration-time $error.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: reset, asynchronous and active-low; all state registers are cleared while rst=0.
- flush, input, 1: synchronous abort, returns the block to IDLE.
- in_valid, input, 1: plaintext valid.
- in_ready, output, 1: block can accept plaintext.
- in_data, input, 128: plaintext, byte 0 in bits [127:120], column-major as in FIPS-197.
- rk_idx, output, 4: index (0..Nr) of the round key required this cycle.
- rk, input, 128: round key for rk_idx, supplied combinationally in the same cycle.
- out_valid, output, 1: ciphertext valid.
- out_ready, input, 1: consumer accepts ciphertext.
- out_data, output, 128: ciphertext.
- busy, output, 1: high in every state except IDLE.

## Operation
- FSM states are IDLE, INIT, ROUND, FINAL and DONE.
- IDLE:
  - in_ready=1.
  - When in_valid&in_ready: state_reg<=in_data, rnd<=0, go to INIT.
- INIT:
  - rk_idx=0; state_reg<=state_reg^rk.
  - rnd<=1; go to ROUND.
- ROUND (rnd = 1..Nr-1):
  - rk_idx=rnd.
  - state_reg<=AddRoundKey(MixColumns(ShiftRows(SubBytes(state_reg))), rk).
  - rnd increments. When rnd==Nr-1 the next state is FINAL.
- FINAL:
  - rk_idx=Nr.
  - state_reg<=ShiftRows(SubBytes(state_reg))^rk, with no MixColumns.
  - Go to DONE.
- DONE:
  - out_valid=1 and out_data=state_reg, both held stable until out_valid&out_ready.
  - On that handshake, go to IDLE.
  - in_ready=0 in DONE; there is no input/output overlap.
- Datapath:
  - SubBytes uses 16 instances of the team's shared forward S-box.
  - MixColumns uses xtime over GF(2^8) with reduction polynomial 0x11b.
  - All byte arithmetic is 8-bit and wraps modulo the field.
- rk_idx is 0 in IDLE and DONE. It is driven from registered state only, so it never depends combinationally on rk.
- flush:
  - Takes priority over every other event in every state.
  - Next edge: IDLE, out_valid=0, rnd=0. state_reg is not cleared.
  - flush together with in_valid in IDLE does not accept the plaintext.
- Asynchronous reset mid-operation aborts immediately. There is no partial output and the block restarts in IDLE.

## Timing
- Reset values:
  - in_ready=1, out_valid=0, out_data=0 (state_reg=0), rk_idx=0, busy=0.
  - FSM=IDLE, rnd=0.
- Latency is counted from the accepting edge to out_valid=1:
  - Without the split: Nr+1 edges, i.e. 11, 13 or 15.
  - With the split: 2·Nr+1 edges, i.e. 21, 25 or 29.
- Throughput:
  - The next in_ready comes 1 cycle after the output handshake.
  - Best-case initiation interval is Nr+3 cycles, or 2·Nr+3 with the split.
- Output stalls: out_ready=0 holds DONE indefinitely. out_data stays constant and the key index is not advanced.
- The combinational path rk -> state_reg is the critical path. rk must settle within the same cycle that rk_idx is presented.

## Configuration
- AES_ITER_SPLIT_EN defined:
  - Adds a 128-bit pipeline register after ShiftRows. Each ROUND and FINAL is split into an A phase (SubBytes+ShiftRows into mid_reg) and a B phase (MixColumns, if applicable, plus AddRoundKey into state_reg).
  - rk_idx is valid and must be stable during the B phase. During the A phase it shows the same value.
  - mid_reg resets to 0, and flush leaves it untouched.
- AES_ITER_SPLIT_EN undefined: one round per cycle as above, and mid_reg is not present.

## Test plan
- KEY_BITS=128, bench key schedule from key 000102…0f, in_data 00112233445566778899aabbccddeeff:
  - out_data must be 69c4e0d86a7b0430d8cdb78070b4c55a.
  - out_valid must rise 11 edges after accept (21 with split).
- KEY_BITS=192, key 000102…17, same plaintext: out_data dda97ca4864cdfe06eaf70a0ec0d7191, with rk_idx stepping 0..12 once each.
- KEY_BITS=256, key 000102…1f, same plaintext: out_data 8ea2b7ca516745bfeafc49904b496089, with latency 15 (29 with split).
- Backpressure: hold out_ready=0 for 20 cycles, then pulse it.
  - out_data stays constant and in_ready stays 0 throughout the stall.
  - in_ready=1 on the cycle after the handshake.
- flush asserted in ROUND with rnd=5: next cycle shows IDLE, in_ready=1, out_valid=0. A following encryption of the 128-bit vector then produces the correct ciphertext.
- rst driven low asynchronously mid-FINAL:
  - All outputs take their reset values without waiting for a clock edge.
  - No out_valid pulse appears after release.
